prio_enc_arb: RTL and testbench

Parametrised, registered successor to the 8:3 combinational priority encoder. Samples an N-bit request vector, selects one winner by fixed priority or round-robin, and presents it as an index plus one-hot grant under a valid/ready handshake. The block sits between request sources, such as interrupt lines or channel-pending flags, and a single downstream consumer that accepts one grant per handshake.

---
 rtl/prio_enc_arb.sv | 168 ++++++++++++++++
 tb/tb_prio_enc_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_arb.sv
// prio_enc_arb
// Registered N-way request arbiter with a valid/ready grant interface.
// A winner is chosen from the request vector either by fixed priority
// (highest index wins) or round-robin (the previously granted index has the
// lowest priority), then held on the outputs until the consumer accepts it.
// On acceptance the requests are re-arbitrated in the same edge, so a
// continuously ready consumer sees one grant per cycle with no bubbles.
//
// Parameters:
//   N    - number of request lines (>= 2)
//   W    - index width, clog2(N)
//   MODE - 0: fixed priority, 1: round-robin
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   req        - level request vector, bit i requests grant i
//   gnt_ready  - consumer accepts the held grant this cycle
//   gnt_valid  - a grant is held on gnt_idx / gnt_onehot
//   gnt_idx    - binary index of the held grant (kept after the grant drains)
//   gnt_onehot - one-hot form of gnt_idx, zero when no grant is held
//   idle       - no grant is held (always ~gnt_valid)
module prio_enc_arb #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         idle
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Highest set bit wins; result is {found, index}. Once a winner is found the
  // lower bits only meet an OR with 1 and a gated select, so unknown bits below
  // the winner cannot disturb the result.
  function automatic logic [W:0] pick_fixed(input logic [N-1:0] r);
    logic         found;
    logic [W-1:0] idx;
    logic [W-1:0] pos;
    found = 1'b0;
    idx   = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      pos   = W'(i);
      idx   = (!found && r[pos]) ? pos : idx;
      found = found | r[pos];
    end
    return {found, idx};
  endfunction

  // Round-robin: search descends from last-1 and wraps from 0 to N-1, so the
  // index granted last is visited at the very end.
  function automatic logic [W:0] pick_rr(input logic [N-1:0] r,
                                         input logic [W-1:0] last);
    logic         found;
    logic [W-1:0] idx;
    logic [W-1:0] pos;
    found = 1'b0;
    idx   = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      pos   = W'((int'(last) + N - 1 - k) % N);
      idx   = (!found && r[pos]) ? pos : idx;
      found = found | r[pos];
    end
    return {found, idx};
  endfunction

  state_t       state_r;
  logic         gnt_valid_r;
  logic [W-1:0] gnt_idx_r;
  logic [N-1:0] gnt_onehot_r;
  logic         idle_r;
  logic [W-1:0] last_r;

  logic [W-1:0] search_last_s;
  logic [W:0]   pick_s;
  logic         sel_any_s;
  logic [W-1:0] sel_idx_s;
  logic [N-1:0] sel_onehot_s;

  // Pointer used for this edge's selection: an accept in round-robin mode
  // moves the pointer to the accepted index before re-arbitrating.
  always_comb begin
    search_last_s = last_r;
    if ((MODE == 1) && (state_r == ST_GRANT) && gnt_ready) begin
      search_last_s = gnt_idx_r;
    end else begin
      search_last_s = last_r;
    end
  end

  // Winner selection for the configured arbitration mode.
  always_comb begin
    pick_s = {(W + 1){1'b0}};
    if (MODE == 1) begin
      pick_s = pick_rr(req, search_last_s);
    end else begin
      pick_s = pick_fixed(req);
    end
  end

  assign sel_any_s    = pick_s[W];
  assign sel_idx_s    = pick_s[W-1:0];
  assign sel_onehot_s = {{(N - 1){1'b0}}, 1'b1} << sel_idx_s;

  // Grant state machine: load a winner from IDLE, hold it until accepted,
  // then reload without a bubble or drain to IDLE when nothing is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gnt_valid_r  <= 1'b0;
      gnt_idx_r    <= {W{1'b0}};
      gnt_onehot_r <= {N{1'b0}};
      idle_r       <= 1'b1;
      last_r       <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_any_s) begin
            state_r      <= ST_GRANT;
            gnt_valid_r  <= 1'b1;
            gnt_idx_r    <= sel_idx_s;
            gnt_onehot_r <= sel_onehot_s;
            idle_r       <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Without gnt_ready the held grant ignores any change on req.
          if (gnt_ready) begin
            if (MODE == 1) begin
              last_r <= gnt_idx_r;
            end
            if (sel_any_s) begin
              gnt_idx_r    <= sel_idx_s;
              gnt_onehot_r <= sel_onehot_s;
            end else begin
              // gnt_idx keeps the last granted index on purpose.
              state_r      <= ST_IDLE;
              gnt_valid_r  <= 1'b0;
              gnt_onehot_r <= {N{1'b0}};
              idle_r       <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          gnt_valid_r  <= 1'b0;
          gnt_onehot_r <= {N{1'b0}};
          idle_r       <= 1'b1;
        end
      endcase
    end
  end

  assign gnt_valid  = gnt_valid_r;
  assign gnt_idx    = gnt_idx_r;
  assign gnt_onehot = gnt_onehot_r;
  assign idle       = idle_r;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Testbench for prio_enc_arb: three instances (N=8 fixed, N=8 round-robin,
// N=16 fixed). Each applied vector pushes its expected grant onto a
// scoreboard queue; after the clock edge the entry is popped and compared
// with the addressed instance's outputs.
module tb_prio_enc_arb;

  logic        clk;
  logic        rst;

  logic [7:0]  req_a;
  logic        rdy_a;
  logic        valid_a;
  logic [2:0]  idx_a;
  logic [7:0]  oh_a;
  logic        idle_a;

  logic [7:0]  req_b;
  logic        rdy_b;
  logic        valid_b;
  logic [2:0]  idx_b;
  logic [7:0]  oh_b;
  logic        idle_b;

  logic [15:0] req_c;
  logic        rdy_c;
  logic        valid_c;
  logic [3:0]  idx_c;
  logic [15:0] oh_c;
  logic        idle_c;

  int vectors;
  int miscompares;

  typedef struct {
    string tag;
    int    dut;
    bit    valid;
    int    idx;
  } exp_t;

  exp_t sb[$];

  prio_enc_arb #(.N(8), .W(3), .MODE(0)) u_fix8 (
    .clk(clk), .rst(rst), .req(req_a), .gnt_ready(rdy_a),
    .gnt_valid(valid_a), .gnt_idx(idx_a), .gnt_onehot(oh_a), .idle(idle_a)
  );

  prio_enc_arb #(.N(8), .W(3), .MODE(1)) u_rr8 (
    .clk(clk), .rst(rst), .req(req_b), .gnt_ready(rdy_b),
    .gnt_valid(valid_b), .gnt_idx(idx_b), .gnt_onehot(oh_b), .idle(idle_b)
  );

  prio_enc_arb #(.N(16), .W(4), .MODE(0)) u_fix16 (
    .clk(clk), .rst(rst), .req(req_c), .gnt_ready(rdy_c),
    .gnt_valid(valid_c), .gnt_idx(idx_c), .gnt_onehot(oh_c), .idle(idle_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input exp_t e);
    logic [31:0] v;
    logic [31:0] i;
    logic [31:0] oh;
    logic [31:0] id;
    logic [31:0] exp_oh;
    case (e.dut)
      0:       begin v = 32'(valid_a); i = 32'(idx_a); oh = 32'(oh_a); id = 32'(idle_a); end
      1:       begin v = 32'(valid_b); i = 32'(idx_b); oh = 32'(oh_b); id = 32'(idle_b); end
      default: begin v = 32'(valid_c); i = 32'(idx_c); oh = 32'(oh_c); id = 32'(idle_c); end
    endcase
    exp_oh = e.valid ? (32'd1 << e.idx) : 32'd0;
    chk({e.tag, ".valid"},  v,  32'(e.valid));
    chk({e.tag, ".idx"},    i,  32'(e.idx));
    chk({e.tag, ".onehot"}, oh, exp_oh);
    chk({e.tag, ".idle"},   id, 32'(!e.valid));
  endtask

  // Drive one vector on instance d, record the expected outcome, clock once,
  // then pop and compare.
  task automatic step(input int d, input string tag, input logic [15:0] r,
                      input bit rdy, input bit ev, input int ei);
    exp_t e;
    case (d)
      0:       begin req_a = r[7:0]; rdy_a = rdy; end
      1:       begin req_b = r[7:0]; rdy_b = rdy; end
      default: begin req_c = r;      rdy_c = rdy; end
    endcase
    e.tag   = tag;
    e.dut   = d;
    e.valid = ev;
    e.idx   = ei;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask

  logic [7:0] sweep_req [8];
  int         sweep_idx [8];
  int         rr_exp [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    sweep_req = '{8'b000001xx, 8'b00100010, 8'b00000100, 8'b10001100,
                  8'b00010000, 8'b01000000, 8'b1000xxxx, 8'b00000001};
    sweep_idx = '{2, 5, 2, 7, 4, 6, 7, 0};
    rr_exp    = '{7, 4, 1, 7, 4, 1};

    rst   = 1'b1;
    req_a = 8'h00;  rdy_a = 1'b0;
    req_b = 8'h00;  rdy_b = 1'b0;
    req_c = 16'h0;  rdy_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      e.tag = $sformatf("reset.%0d", d);
      e.dut = d;
      e.valid = 1'b0;
      e.idx = 0;
      check_out(e);
    end
    rst = 1'b0;

    // Fixed-priority sweep with a continuously ready consumer.
    for (int i = 0; i < 8; i++) begin
      step(0, $sformatf("fix.%0d", i), {8'h00, sweep_req[i]}, 1'b1, 1'b1, sweep_idx[i]);
    end
    step(0, "fix.idle", 16'h0000, 1'b1, 1'b0, 0);

    // Backpressure: grant 3 held for four cycles while req changes.
    step(0, "hold.1", 16'h000A, 1'b0, 1'b1, 3);
    step(0, "hold.2", 16'h0001, 1'b0, 1'b1, 3);
    step(0, "hold.3", 16'h0001, 1'b0, 1'b1, 3);
    step(0, "hold.4", 16'h0001, 1'b0, 1'b1, 3);
    step(0, "hold.acc", 16'h0001, 1'b1, 1'b1, 0);
    step(0, "hold.drain", 16'h0000, 1'b1, 1'b0, 0);

    // Asynchronous reset while round-robin instance holds grant 5.
    step(1, "rst.pre", 16'h0020, 1'b0, 1'b1, 5);
    #2 rst = 1'b1;
    #1;
    chk("rst.async.valid",  32'(valid_b), 32'd0);
    chk("rst.async.onehot", 32'(oh_b),    32'd0);
    chk("rst.async.idle",   32'(idle_b),  32'd1);
    chk("rst.async.idx",    32'(idx_b),   32'd0);
    #1 rst = 1'b0;
    step(1, "rst.first", 16'h00FF, 1'b1, 1'b1, 7);

    // Fresh pointer, then round-robin fairness with constant requests.
    req_b = 8'h00;
    rdy_b = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1, $sformatf("rr.%0d", i), 16'h0092, 1'b1, 1'b1, rr_exp[i]);
    end
    step(1, "drain.grant", 16'h0004, 1'b1, 1'b1, 2);
    step(1, "drain.idle", 16'h0000, 1'b1, 1'b0, 2);

    // Generic width.
    step(2, "w16.hi", 16'h8001, 1'b1, 1'b1, 15);
    step(2, "w16.lo", 16'h0001, 1'b1, 1'b1, 0);
    step(2, "w16.idle", 16'h0000, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
